// File: rtl/rescale_pkg.sv
// -----------------------------------------------------------------------------
// rescale_pkg
//  Shared definitions for the convolution->rescale frame controller.
//  - DEF_NB_* : default widths (pixel, size counters, RAM address)
//  - state_t  : 3-bit FSM encoding, also exported on the debug state output
//  - range_width() : width of the unsigned max-min range for a pixel width
// -----------------------------------------------------------------------------
package rescale_pkg;

  localparam int DEF_NB_PIXEL = 19;
  localparam int DEF_NB_COUNT = 32;
  localparam int DEF_NB_ADDR  = 18;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_WRITE = 3'd2,
    ST_LATCH = 3'd3,
    ST_READ  = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  // Difference of two signed N-bit values needs N+1 bits to never overflow.
  function automatic int range_width(input int nb_pixel);
    return nb_pixel + 1;
  endfunction

endpackage

// File: rtl/pixel_addr_counter.sv
// -----------------------------------------------------------------------------
// pixel_addr_counter
//  Frame address counter used for both the write pass and the read pass.
//  Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : synchronous clear to 0 (start of frame)
//   inc          : advance count by one this cycle
//   size         : number of pixels in the frame
//   count        : current address (wraps to 0 after 2^NB_ADDR - 1)
//   last         : count addresses the final pixel of the frame (size-1)
// -----------------------------------------------------------------------------
module pixel_addr_counter
  import rescale_pkg::*;
#(
  parameter int NB_COUNT = DEF_NB_COUNT,
  parameter int NB_ADDR  = DEF_NB_ADDR
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic                inc,
  input  logic [NB_COUNT-1:0] size,
  output logic [NB_ADDR-1:0]  count,
  output logic                last
);

  localparam logic [NB_ADDR-1:0]  ADDR_ONE  = 1;
  localparam logic [NB_COUNT-1:0] COUNT_ONE = 1;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      // For a full 2^NB_ADDR frame this wraps to 0 only after the final access.
      count <= count + ADDR_ONE;
    end
  end

  // size is already range-checked to [1, 2^NB_ADDR], so size-1 fits in NB_ADDR bits.
  assign last = ({{(NB_COUNT-NB_ADDR){1'b0}}, count} == (size - COUNT_ONE));

endmodule

// File: rtl/rescale_sequencer.sv
// -----------------------------------------------------------------------------
// rescale_sequencer
//  Two-pass frame controller for the convolution->rescale path.
//  Pass 1 stores every convolution result in the result RAM while the external
//  extreme-search block tracks max/min. Between passes the extremes are latched
//  and the range computed. Pass 2 replays the RAM to the rescaler, then pulses
//  o_done.
//  Ports:
//   clock, reset                 : rising-edge clock, synchronous active-high reset
//   i_start, i_imageSize         : frame start pulse and pixel count (IDLE only)
//   i_convValid, i_convValue     : pass-1 pixel stream
//   o_searchReset, o_searchValid : controls to the extreme-search block
//   i_searchMax, i_searchMin     : extremes from the search block
//   o_memWr*                     : registered RAM write port
//   o_memRdEn, o_memRdAddr       : RAM read port (1-cycle read latency)
//   i_rescaleReady, o_rescaleValid : rescaler handshake
//   o_scaleMin, o_scaleRange, o_rangeZero : latched scaling parameters
//   o_busy, o_done, o_error      : status
//   o_state                      : FSM state (debug)
//
//  Rescaler handshake: i_rescaleReady high in cycle N means the rescaler will
//  accept a word in cycle N+1. A read is issued (o_memRdEn) in exactly the READ
//  cycles where i_rescaleReady is high, and the RAM data is presented with
//  o_rescaleValid one cycle later. No word is presented without a prior ready,
//  and a stall (ready low) freezes the read address.
// -----------------------------------------------------------------------------
module rescale_sequencer
  import rescale_pkg::*;
#(
  parameter int NB_PIXEL = DEF_NB_PIXEL,
  parameter int NB_COUNT = DEF_NB_COUNT,
  parameter int NB_ADDR  = DEF_NB_ADDR
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 i_start,
  input  logic [NB_COUNT-1:0]                  i_imageSize,
  input  logic                                 i_convValid,
  input  logic signed [NB_PIXEL-1:0]           i_convValue,
  output logic                                 o_searchReset,
  output logic                                 o_searchValid,
  input  logic signed [NB_PIXEL-1:0]           i_searchMax,
  input  logic signed [NB_PIXEL-1:0]           i_searchMin,
  output logic                                 o_memWrEn,
  output logic [NB_ADDR-1:0]                   o_memWrAddr,
  output logic [NB_PIXEL-1:0]                  o_memWrData,
  output logic                                 o_memRdEn,
  output logic [NB_ADDR-1:0]                   o_memRdAddr,
  input  logic                                 i_rescaleReady,
  output logic                                 o_rescaleValid,
  output logic signed [NB_PIXEL-1:0]           o_scaleMin,
  output logic [range_width(NB_PIXEL)-1:0]     o_scaleRange,
  output logic                                 o_rangeZero,
  output logic                                 o_busy,
  output logic                                 o_done,
  output logic                                 o_error,
  output logic [2:0]                           o_state
);

  localparam int NB_RANGE = range_width(NB_PIXEL);
  localparam logic [NB_COUNT:0] SIZE_ONE = 1;
  localparam logic [NB_COUNT:0] MAX_SIZE = SIZE_ONE << NB_ADDR;
  localparam logic [NB_RANGE-1:0] RANGE_ONE = 1;

  state_t state, state_next;

  logic [NB_COUNT-1:0] size_q;
  logic                size_ok;
  logic                start_ok;
  logic                wr_fire, rd_fire;
  logic                wr_last, rd_last;
  logic [NB_ADDR-1:0]  wr_count, rd_count;
  logic                frame_clear;
  logic signed [NB_RANGE-1:0] range_diff;

  assign size_ok     = (i_imageSize != '0) && ({1'b0, i_imageSize} <= MAX_SIZE);
  assign start_ok    = (state == ST_IDLE) && i_start && size_ok;
  assign wr_fire     = (state == ST_WRITE) && i_convValid;
  assign rd_fire     = (state == ST_READ) && i_rescaleReady;
  assign frame_clear = (state == ST_CLEAR);

  // Sign-extend both extremes before subtracting so the full span fits.
  assign range_diff = {i_searchMax[NB_PIXEL-1], i_searchMax}
                    - {i_searchMin[NB_PIXEL-1], i_searchMin};

  pixel_addr_counter #(
    .NB_COUNT (NB_COUNT),
    .NB_ADDR  (NB_ADDR)
  ) u_wr_counter (
    .clock (clock),
    .reset (reset),
    .clear (frame_clear),
    .inc   (wr_fire),
    .size  (size_q),
    .count (wr_count),
    .last  (wr_last)
  );

  pixel_addr_counter #(
    .NB_COUNT (NB_COUNT),
    .NB_ADDR  (NB_ADDR)
  ) u_rd_counter (
    .clock (clock),
    .reset (reset),
    .clear (frame_clear),
    .inc   (rd_fire),
    .size  (size_q),
    .count (rd_count),
    .last  (rd_last)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_ok) state_next = ST_CLEAR;
      ST_CLEAR: state_next = ST_WRITE;
      ST_WRITE: if (wr_fire && wr_last) state_next = ST_LATCH;
      ST_LATCH: state_next = ST_READ;
      ST_READ:  if (rd_fire && rd_last) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Combinational outputs decoded from state.
  always_comb begin
    o_searchReset = reset || (state == ST_CLEAR);
    o_searchValid = (state == ST_LATCH);
    o_memRdEn     = rd_fire;
    o_memRdAddr   = rd_count;
    o_busy        = (state != ST_IDLE);
    o_done        = (state == ST_DONE);
    o_state       = state;
  end

  // Registered datapath: write port, read-valid pipe, status pulses, scale latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      size_q         <= '0;
      o_memWrEn      <= 1'b0;
      o_memWrAddr    <= '0;
      o_memWrData    <= '0;
      o_rescaleValid <= 1'b0;
      o_error        <= 1'b0;
      o_scaleMin     <= '0;
      o_scaleRange   <= '0;
      o_rangeZero    <= 1'b0;
    end else begin
      o_memWrEn      <= wr_fire;
      o_rescaleValid <= rd_fire;
      o_error        <= (state == ST_IDLE) && i_start && !size_ok;

      if (wr_fire) begin
        o_memWrAddr <= wr_count;
        o_memWrData <= i_convValue;
      end

      if (start_ok) begin
        size_q <= i_imageSize;
      end

      if (state == ST_CLEAR) begin
        o_scaleMin   <= '0;
        o_scaleRange <= '0;
        o_rangeZero  <= 1'b0;
      end else if (state == ST_LATCH) begin
        o_scaleMin <= i_searchMin;
        // A flat frame (or an inconsistent max<min) is reported as range 0;
        // the range output is forced to 1 so the rescaler never divides by 0.
        if (range_diff[NB_RANGE-1] || (range_diff == '0)) begin
          o_scaleRange <= RANGE_ONE;
          o_rangeZero  <= 1'b1;
        end else begin
          o_scaleRange <= range_diff;
          o_rangeZero  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rescale_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rescale_sequencer
//  Bench for rescale_sequencer. A negedge monitor records the RAM write port,
//  read issues, words handed to the rescaler (via a RAM model with one cycle
//  of read latency) and status pulses. Each test task drives a frame and
//  compares those records against expectations derived from the frame's
//  pixel list: addresses 0..n-1, readback equal to the written list, min/max
//  of the list, and the frame length 2n + gaps + stalls + 4.
// -----------------------------------------------------------------------------
module tb_rescale_sequencer;

  localparam int NB_PIXEL = 19;
  localparam int NB_COUNT = 32;
  localparam int NB_ADDR  = 18;
  localparam int NB_RANGE = 20;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic                       i_start = 0;
  logic [NB_COUNT-1:0]        i_imageSize = '0;
  logic                       i_convValid = 0;
  logic signed [NB_PIXEL-1:0] i_convValue = '0;
  logic signed [NB_PIXEL-1:0] i_searchMax = '0;
  logic signed [NB_PIXEL-1:0] i_searchMin = '0;
  logic                       i_rescaleReady = 1;
  logic o_searchReset, o_searchValid, o_memWrEn, o_memRdEn, o_rescaleValid;
  logic o_rangeZero, o_busy, o_done, o_error;
  logic [NB_ADDR-1:0]         o_memWrAddr, o_memRdAddr;
  logic [NB_PIXEL-1:0]        o_memWrData;
  logic signed [NB_PIXEL-1:0] o_scaleMin;
  logic [NB_RANGE-1:0]        o_scaleRange;
  logic [2:0]                 o_state;

  rescale_sequencer dut (
    .clock(clock), .reset(reset), .i_start(i_start), .i_imageSize(i_imageSize),
    .i_convValid(i_convValid), .i_convValue(i_convValue),
    .o_searchReset(o_searchReset), .o_searchValid(o_searchValid),
    .i_searchMax(i_searchMax), .i_searchMin(i_searchMin),
    .o_memWrEn(o_memWrEn), .o_memWrAddr(o_memWrAddr), .o_memWrData(o_memWrData),
    .o_memRdEn(o_memRdEn), .o_memRdAddr(o_memRdAddr),
    .i_rescaleReady(i_rescaleReady), .o_rescaleValid(o_rescaleValid),
    .o_scaleMin(o_scaleMin), .o_scaleRange(o_scaleRange), .o_rangeZero(o_rangeZero),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_state(o_state)
  );

  // ---------------- scoreboard state ----------------
  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  int vals[$];
  int model_max, model_min, model_range;
  int gaps, stalls;
  logic [NB_PIXEL-1:0] exp_q[$];

  logic [NB_ADDR-1:0]  wr_addr_q[$];
  logic [NB_PIXEL-1:0] wr_data_q[$];
  logic [NB_ADDR-1:0]  rd_addr_q[$];
  logic [NB_ADDR-1:0]  stall_addr_q[$];
  logic [NB_PIXEL-1:0] got_q[$];
  logic [NB_PIXEL-1:0] ram [int];
  logic [NB_PIXEL-1:0] rd_data_q = '0;
  logic prev_rd_en = 0;
  bit   in_read = 0;
  int done_cnt, err_cnt, busy_cyc, busy_start, done_cyc, rv_align_bad;

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      prev_rd_en = 0;
    end else begin
      if (o_rescaleValid) got_q.push_back(rd_data_q);
      if (o_rescaleValid !== prev_rd_en) rv_align_bad++;
      prev_rd_en = o_memRdEn;
      if (o_memRdEn) begin
        rd_addr_q.push_back(o_memRdAddr);
        rd_data_q = ram.exists(int'(o_memRdAddr)) ? ram[int'(o_memRdAddr)] : '0;
      end else if (in_read && !i_rescaleReady) begin
        stall_addr_q.push_back(o_memRdAddr);
      end
      if (o_memWrEn) begin
        wr_addr_q.push_back(o_memWrAddr);
        wr_data_q.push_back(o_memWrData);
        ram[int'(o_memWrAddr)] = o_memWrData;
      end
      if (o_done) begin done_cnt++; done_cyc = cyc; end
      if (o_error) err_cnt++;
      if (o_busy) begin
        busy_cyc++;
        if (busy_start < 0) busy_start = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
    stall_addr_q.delete(); got_q.delete(); ram.delete();
    done_cnt = 0; err_cnt = 0; busy_cyc = 0; busy_start = -1; done_cyc = -1;
    rv_align_bad = 0;
  endtask

  task automatic do_reset();
    reset = 1; i_start = 0; i_convValid = 0; i_rescaleReady = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
  endtask

  function automatic int rand_pixel();
    logic [NB_PIXEL-1:0] r;
    r = NB_PIXEL'($urandom);
    return int'($signed(r));
  endfunction

  // Reference model: extremes and range straight from the pixel list.
  task automatic build_model();
    model_max = vals[0];
    model_min = vals[0];
    exp_q.delete();
    foreach (vals[i]) begin
      if (vals[i] > model_max) model_max = vals[i];
      if (vals[i] < model_min) model_min = vals[i];
      exp_q.push_back(NB_PIXEL'(vals[i]));
    end
    model_range = (model_max == model_min) ? 1 : model_max - model_min;
    // Ideal zero-latency search block: extremes already valid at LATCH.
    i_searchMax = NB_PIXEL'(model_max);
    i_searchMin = NB_PIXEL'(model_min);
  endtask

  task automatic drive_frame(input int gap_pct, input int stall_pct,
                             input logic [31:0] stall_mask, input bit poke);
    int n, idx, k, guard;
    n = vals.size();
    build_model();
    clear_logs();
    gaps = 0; stalls = 0;
    @(posedge clock); #1 i_start = 1; i_imageSize = NB_COUNT'(n);
    @(posedge clock); #1 i_start = 0;
    @(posedge clock); #1;
    idx = 0; guard = 0;
    while (idx < n && guard < 20 * n + 20) begin
      guard++;
      if ($urandom_range(99) < gap_pct) begin
        i_convValid = 0; gaps++;
      end else begin
        i_convValid = 1; i_convValue = NB_PIXEL'(vals[idx]); idx++;
      end
      @(posedge clock); #1;
    end
    i_convValid = 0;
    @(posedge clock); #1;
    in_read = 1;
    k = 0;
    while (done_cnt == 0 && k < 8 * n + 60) begin
      if ((k < 32 && stall_mask[k]) || ($urandom_range(99) < stall_pct)) begin
        i_rescaleReady = 0;
        if (rd_addr_q.size() < n) stalls++;
      end else begin
        i_rescaleReady = 1;
      end
      if (poke) begin
        i_start = 1; i_imageSize = NB_COUNT'($urandom_range(1, 8));
        i_convValid = 1; i_convValue = NB_PIXEL'($urandom);
      end
      @(posedge clock); #1;
      k++;
    end
    i_start = 0; i_convValid = 0; i_rescaleReady = 1; in_read = 0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if ({o_busy, o_done, o_error, o_memWrEn, o_memRdEn, o_rescaleValid,
         o_searchValid, o_searchReset, o_rangeZero} !== 9'b0_0000_0010) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got busy=%b done=%b err=%b wr=%b rd=%b rv=%b sv=%b sr=%b rz=%b want all 0, searchReset 1",
               o_busy, o_done, o_error, o_memWrEn, o_memRdEn, o_rescaleValid,
               o_searchValid, o_searchReset, o_rangeZero);
    end
    tests_run++;
    if ({o_scaleMin, o_scaleRange, o_memWrAddr, o_memWrData, o_memRdAddr} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: got min=%0h range=%0h wra=%0h wrd=%0h rda=%0h want 0",
               o_scaleMin, o_scaleRange, o_memWrAddr, o_memWrData, o_memRdAddr);
    end
    @(posedge clock); #1 reset = 0;
    @(negedge clock);
    tests_run++;
    if (o_searchReset !== 1'b0 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got searchReset=%b busy=%b want 0 0", o_searchReset, o_busy);
    end
  endtask

  task automatic test_basic();
    do_reset();
    vals = '{5, -3, 100, 7};
    drive_frame(40, 0, 32'h0, 1'b0);
    tests_run++;
    if (done_cnt !== 1) begin tests_failed++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
    tests_run++;
    if (wr_addr_q.size() !== 4) begin tests_failed++; $display("FAIL basic_wr_count: got %0d want 4", wr_addr_q.size()); end
    foreach (wr_addr_q[i]) begin
      tests_run++;
      if (wr_addr_q[i] !== NB_ADDR'(i) || wr_data_q[i] !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL basic_wr[%0d]: got addr=%0d data=%0h want addr=%0d data=%0h", i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]);
      end
    end
    tests_run++;
    if (o_scaleMin !== NB_PIXEL'(-3) || o_scaleRange !== NB_RANGE'(103) || o_rangeZero !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_scale: got min=%0d range=%0d zero=%b want -3 103 0", o_scaleMin, o_scaleRange, o_rangeZero);
    end
    tests_run++;
    if (got_q.size() !== 4) begin tests_failed++; $display("FAIL basic_rd_count: got %0d want 4", got_q.size()); end
    foreach (got_q[i]) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL basic_rd[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
    tests_run++;
    if (done_cyc - busy_start + 1 !== 2 * 4 + gaps + stalls + 4) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d want %0d", done_cyc - busy_start + 1, 2 * 4 + gaps + stalls + 4);
    end
  endtask

  task automatic test_zero_range();
    do_reset();
    vals = '{42, 42, 42};
    drive_frame(20, 20, 32'h0, 1'b0);
    tests_run++;
    if (o_rangeZero !== 1'b1 || o_scaleRange !== NB_RANGE'(1) || o_scaleMin !== NB_PIXEL'(42)) begin
      tests_failed++;
      $display("FAIL zero_scale: got zero=%b range=%0d min=%0d want 1 1 42", o_rangeZero, o_scaleRange, o_scaleMin);
    end
    tests_run++;
    if (done_cnt !== 1 || got_q.size() !== 3) begin
      tests_failed++;
      $display("FAIL zero_frame: got done=%0d words=%0d want 1 3", done_cnt, got_q.size());
    end
  endtask

  task automatic test_stall();
    do_reset();
    vals.delete();
    repeat (4) vals.push_back(rand_pixel());
    drive_frame(0, 0, 32'b110, 1'b0);
    tests_run++;
    if (rd_addr_q.size() !== 4) begin tests_failed++; $display("FAIL stall_issues: got %0d want 4", rd_addr_q.size()); end
    foreach (rd_addr_q[i]) begin
      tests_run++;
      if (rd_addr_q[i] !== NB_ADDR'(i)) begin tests_failed++; $display("FAIL stall_rdaddr[%0d]: got %0d want %0d", i, rd_addr_q[i], i); end
    end
    tests_run++;
    if (stall_addr_q.size() !== 2 || stall_addr_q[0] !== NB_ADDR'(1) || stall_addr_q[1] !== NB_ADDR'(1)) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d entries first=%0d want 2 entries at addr 1", stall_addr_q.size(), stall_addr_q[0]);
    end
    tests_run++;
    if (got_q.size() !== 4) begin tests_failed++; $display("FAIL stall_words: got %0d want 4", got_q.size()); end
    foreach (got_q[i]) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL stall_rd[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
    tests_run++;
    if (rv_align_bad !== 0) begin tests_failed++; $display("FAIL stall_rv_align: got %0d misaligned want 0", rv_align_bad); end
    tests_run++;
    if (done_cyc - busy_start + 1 !== 2 * 4 + 2 + 4) begin
      tests_failed++;
      $display("FAIL stall_latency: got %0d want %0d", done_cyc - busy_start + 1, 14);
    end
  endtask

  task automatic test_size_limits();
    logic [NB_COUNT-1:0] bad_sizes [2];
    bad_sizes[0] = '0;
    bad_sizes[1] = (NB_COUNT'(1) << NB_ADDR) + NB_COUNT'(1);
    do_reset();
    for (int s = 0; s < 2; s++) begin
      clear_logs();
      @(posedge clock); #1 i_start = 1; i_imageSize = bad_sizes[s];
      @(posedge clock); #1 i_start = 0;
      repeat (3) @(posedge clock);
      #1;
      tests_run++;
      if (err_cnt !== 1 || busy_cyc !== 0) begin
        tests_failed++;
        $display("FAIL size_error[%0d]: got err=%0d busy=%0d want 1 0", s, err_cnt, busy_cyc);
      end
    end
    vals = '{rand_pixel()};
    drive_frame(0, 0, 32'h0, 1'b0);
    tests_run++;
    if (done_cnt !== 1 || wr_addr_q.size() !== 1 || got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL size1_frame: got done=%0d writes=%0d words=%0d word=%0h want 1 1 1 %0h",
               done_cnt, wr_addr_q.size(), got_q.size(), got_q[0], exp_q[0]);
    end
    tests_run++;
    if (done_cyc - busy_start + 1 !== 6) begin
      tests_failed++;
      $display("FAIL size1_latency: got %0d want 6", done_cyc - busy_start + 1);
    end
    tests_run++;
    if (o_rangeZero !== 1'b1 || o_scaleMin !== exp_q[0]) begin
      tests_failed++;
      $display("FAIL size1_scale: got zero=%b min=%0h want 1 %0h", o_rangeZero, o_scaleMin, exp_q[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    clear_logs();
    @(posedge clock); #1 i_start = 1; i_imageSize = NB_COUNT'(8);
    @(posedge clock); #1 i_start = 0;
    @(posedge clock); #1;
    repeat (3) begin
      i_convValid = 1; i_convValue = NB_PIXEL'($urandom);
      @(posedge clock); #1;
    end
    i_convValid = 0; reset = 1;
    @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (o_busy !== 1'b0 || o_memWrEn !== 1'b0 || o_searchReset !== 1'b1 || o_scaleRange !== '0) begin
      tests_failed++;
      $display("FAIL midreset_out: got busy=%b wr=%b sr=%b range=%0d want 0 0 1 0", o_busy, o_memWrEn, o_searchReset, o_scaleRange);
    end
    @(posedge clock); #1 reset = 0;
    repeat (4) @(posedge clock);
    #1;
    tests_run++;
    if (done_cnt !== 0 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_nodone: got done=%0d busy=%b want 0 0", done_cnt, o_busy);
    end
    vals.delete();
    repeat (6) vals.push_back(rand_pixel());
    drive_frame(25, 25, 32'h0, 1'b0);
    tests_run++;
    if (wr_addr_q.size() !== 6 || wr_addr_q[0] !== '0 || wr_addr_q[5] !== NB_ADDR'(5)) begin
      tests_failed++;
      $display("FAIL midreset_wraddr: got n=%0d first=%0d last=%0d want 6 0 5", wr_addr_q.size(), wr_addr_q[0], wr_addr_q[5]);
    end
    foreach (got_q[i]) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL midreset_rd[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
    tests_run++;
    if (done_cnt !== 1 || got_q.size() !== 6) begin
      tests_failed++;
      $display("FAIL midreset_frame: got done=%0d words=%0d want 1 6", done_cnt, got_q.size());
    end
  endtask

  task automatic test_ignore_during_read();
    do_reset();
    vals.delete();
    repeat (5) vals.push_back(rand_pixel());
    drive_frame(0, 30, 32'h0, 1'b1);
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if (wr_addr_q.size() !== 5 || done_cnt !== 1 || err_cnt !== 0 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_frame: got writes=%0d done=%0d err=%0d busy=%b want 5 1 0 0",
               wr_addr_q.size(), done_cnt, err_cnt, o_busy);
    end
    tests_run++;
    if (got_q.size() !== 5) begin tests_failed++; $display("FAIL ignore_words: got %0d want 5", got_q.size()); end
    foreach (got_q[i]) begin
      tests_run++;
      if (got_q[i] !== exp_q[i]) begin tests_failed++; $display("FAIL ignore_rd[%0d]: got %0h want %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random_frames();
    int n;
    do_reset();
    for (int f = 0; f < 6; f++) begin
      n = $urandom_range(1, 24);
      vals.delete();
      for (int i = 0; i < n; i++) vals.push_back(rand_pixel());
      drive_frame(25, 25, 32'h0, 1'b0);
      tests_run++;
      if (done_cnt !== 1 || got_q.size() !== n || wr_addr_q.size() !== n) begin
        tests_failed++;
        $display("FAIL rand%0d_counts: got done=%0d words=%0d writes=%0d want 1 %0d %0d",
                 f, done_cnt, got_q.size(), wr_addr_q.size(), n, n);
      end
      foreach (got_q[i]) begin
        tests_run++;
        if (got_q[i] !== exp_q[i] || wr_addr_q[i] !== NB_ADDR'(i)) begin
          tests_failed++;
          $display("FAIL rand%0d_word[%0d]: got data=%0h wraddr=%0d want %0h %0d", f, i, got_q[i], wr_addr_q[i], exp_q[i], i);
        end
      end
      tests_run++;
      if (o_scaleMin !== NB_PIXEL'(model_min) || o_scaleRange !== NB_RANGE'(model_range)
          || o_rangeZero !== (model_max == model_min)) begin
        tests_failed++;
        $display("FAIL rand%0d_scale: got min=%0h range=%0d zero=%b want %0h %0d %b",
                 f, o_scaleMin, o_scaleRange, o_rangeZero, NB_PIXEL'(model_min), model_range, model_max == model_min);
      end
      tests_run++;
      if (done_cyc - busy_start + 1 !== 2 * n + gaps + stalls + 4 || rv_align_bad !== 0) begin
        tests_failed++;
        $display("FAIL rand%0d_timing: got len=%0d misaligned=%0d want %0d 0",
                 f, done_cyc - busy_start + 1, rv_align_bad, 2 * n + gaps + stalls + 4);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_zero_range();
    test_stall();
    test_size_limits();
    test_reset_mid();
    test_ignore_during_read();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, tests_run=%0d", tests_run);
    $fatal(1, "watchdog expired");
  end

endmodule
